pipeline_ctrl_md: RTL and testbench
===================================

PIPELINE_CTRL_MD -- requirements
Module: pipeline_ctrl_md

Interface
REQ-001 SHALL have parameter ALUCW, default 4, ALU control width.
REQ-002 SHALL have parameter MD_LATENCY, default 32, multiply/divide cycles (legal 2..255).
REQ-003 SHALL have parameter CNTW, default $clog2(MD_LATENCY+1), sequencer counter width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have inputs: opD  6  decode opcode; functD  6  decode funct; equalD  1  register compare result; flushE  1  synchronous clear of E controls.
REQ-006 SHALL have decode outputs: pcsrcD, branchD, bneD, jumpD, jrD, each 1 bit.
REQ-007 SHALL have E outputs: regwriteE 1, memtoregE 2, alusrcE 1, regdstE 2, shiftE 1, alucontrolE ALUCW, mdopE 1 (mult/div in E), mdsignedE 1, mddivE 1.
REQ-008 SHALL have M/W outputs: regwriteM 1, memtoregM 2, memwriteM 1, regwriteW 1, memtoregW 2.
REQ-009 SHALL have sequencer outputs: mdbusy 1 (unit occupied), mddone 1 (one-cycle HI/LO write strobe), stallMD 1 (stall F/D, flush E request).

Function
REQ-010 SHALL decode opD/functD combinationally into D-stage controls; unknown opcodes give all-zero controls.
REQ-011 SHALL drive pcsrcD = (branchD & equalD) | (bneD & ~equalD).
REQ-012 SHALL decode R-type funct 011000/011001/011010/011011 (MULT/MULTU/DIV/DIVU) as mdopD with regwriteD=0; mdsignedD = ~functD[0], mddivD = functD[1].
REQ-013 SHALL decode funct 010000/010010 (MFHI/MFLO) as mfhiloD.
REQ-014 SHALL register D controls into E every cycle; E register SHALL load all zeros when flushE=1 or stallMD=1 (bubble).
REQ-015 SHALL register E->M and M->W controls every cycle with no enable; latency D->W exactly 3 cycles.
REQ-016 SHALL implement sequencer states IDLE, BUSY, DONE.
REQ-017 IDLE: mdopE=1 -> BUSY, counter loads MD_LATENCY-2; otherwise stay.
REQ-018 BUSY: counter decrements each cycle; at counter=0 -> DONE.
REQ-019 DONE: mddone=1 for exactly one cycle, -> IDLE; HI/LO written at end of this cycle.
REQ-020 mdbusy SHALL equal (state != IDLE); mdopE to mddone latency SHALL be exactly MD_LATENCY cycles.
REQ-021 stallMD SHALL equal (mdbusy | mdopE) & (mdopD | mfhiloD), combinational.
REQ-022 While stallMD=1 D-stage instruction SHALL be held by hazard logic; this block only emits the bubble per REQ-014.
REQ-023 flushE with mdopD SHALL prevent sequencer start; flushE SHALL NOT abort a BUSY/DONE sequence.
REQ-024 Non-md, non-mfhilo instructions SHALL proceed during BUSY without stall.

Reset
REQ-025 reset=0 SHALL asynchronously clear all E/M/W registers to 0, state to IDLE, counter to 0.
REQ-026 After reset all registered outputs, mdbusy, mddone SHALL be 0; stallMD SHALL be 0 until an md op reaches E.
REQ-027 Reset asserted mid-BUSY SHALL abandon the operation with no mddone pulse.

Structure
REQ-028 Shared package ctrl_pkg SHALL hold opcode/funct constants, md_state_t enum (IDLE, BUSY, DONE), and control-bundle struct typedef.
REQ-029 Sequencer SHALL be a sub-module md_sequencer (clk, reset, mdopE, mdbusy, mddone).

Verification
REQ-030 lw (op 100011) in D -> 1,2,3 cycles later regwriteE=1/memtoregE=01, regwriteM=1, regwriteW=1/memtoregW=01.
REQ-031 beq, equalD=1 -> pcsrcD=1; bne, equalD=1 -> pcsrcD=0; bne, equalD=0 -> pcsrcD=1.
REQ-032 MULT in E at cycle t, MD_LATENCY=32 -> mdbusy=1 cycles t+1..t+32, mddone=1 only at t+32, mdsignedE=1, mddivE=0 at t.
REQ-033 MFLO in D during BUSY -> stallMD=1, E bubble all zero each stalled cycle; stallMD=0 first cycle after DONE.
REQ-034 DIVU in D with flushE=1 -> E controls zero, state stays IDLE, no mddone.
REQ-035 reset=0 mid-BUSY (cycle t+10) -> state IDLE and all outputs 0 immediately, no mddone thereafter.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline controller with multiply/divide sequencing:
// opcode and funct encodings, ALU operation codes, sequencer states and the
// control bundle that travels from decode into the execute stage.
package ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_SRA   = 6'b000011;
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_XOR   = 6'b100110;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLTU  = 6'b101011;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_NOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;
   localparam logic [3:0] ALU_SLTU = 4'b1010;
   localparam logic [3:0] ALU_LUI  = 4'b1011;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } md_state_t;

   typedef struct packed {
      logic       regWrite;
      logic [1:0] memToReg;
      logic       memWrite;
      logic       aluSrc;
      logic [1:0] regDst;
      logic       shift;
      logic [3:0] aluCode;
      logic       mdOp;
      logic       mdSigned;
      logic       mdDiv;
   } ctrl_t;

   // Classifies an R-type funct that writes rd from the ALU.
   // Returns {valid, isShift, aluCode}; valid=0 means the funct is not an ALU op.
   function automatic logic [5:0] rtypeAlu(input logic [5:0] funct);
      logic [5:0] r;
      r = '0;
      case (funct)
         FN_ADD, FN_ADDU : r = {2'b10, ALU_ADD};
         FN_SUB, FN_SUBU : r = {2'b10, ALU_SUB};
         FN_AND          : r = {2'b10, ALU_AND};
         FN_OR           : r = {2'b10, ALU_OR};
         FN_XOR          : r = {2'b10, ALU_XOR};
         FN_NOR          : r = {2'b10, ALU_NOR};
         FN_SLT          : r = {2'b10, ALU_SLT};
         FN_SLTU         : r = {2'b10, ALU_SLTU};
         FN_SLL          : r = {2'b11, ALU_SLL};
         FN_SRL          : r = {2'b11, ALU_SRL};
         FN_SRA          : r = {2'b11, ALU_SRA};
         default         : r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_md_if.sv
// Bundle of decode inputs and stage control outputs of the pipeline controller.
// The controller attaches through the slave modport; the datapath/hazard side
// (or a testbench) uses the master modport.
interface pipeline_ctrl_md_if #(
   parameter int ALUCW = 4
);

   logic [5:0]       opD;
   logic [5:0]       functD;
   logic             equalD;
   logic             flushE;

   logic             pcsrcD;
   logic             branchD;
   logic             bneD;
   logic             jumpD;
   logic             jrD;

   logic             regwriteE;
   logic [1:0]       memtoregE;
   logic             alusrcE;
   logic [1:0]       regdstE;
   logic             shiftE;
   logic [ALUCW-1:0] alucontrolE;
   logic             mdopE;
   logic             mdsignedE;
   logic             mddivE;

   logic             regwriteM;
   logic [1:0]       memtoregM;
   logic             memwriteM;
   logic             regwriteW;
   logic [1:0]       memtoregW;

   logic             mdbusy;
   logic             mddone;
   logic             stallMD;

   modport slave (
      input  opD, functD, equalD, flushE,
      output pcsrcD, branchD, bneD, jumpD, jrD,
      output regwriteE, memtoregE, alusrcE, regdstE, shiftE, alucontrolE,
      output mdopE, mdsignedE, mddivE,
      output regwriteM, memtoregM, memwriteM, regwriteW, memtoregW,
      output mdbusy, mddone, stallMD
   );

   modport master (
      output opD, functD, equalD, flushE,
      input  pcsrcD, branchD, bneD, jumpD, jrD,
      input  regwriteE, memtoregE, alusrcE, regdstE, shiftE, alucontrolE,
      input  mdopE, mdsignedE, mddivE,
      input  regwriteM, memtoregM, memwriteM, regwriteW, memtoregW,
      input  mdbusy, mddone, stallMD
   );

endinterface

// File: rtl/md_sequencer.sv
// Multiply/divide occupancy sequencer. Once a mult/div is in E it counts the
// unit's latency so that mddone pulses exactly MD_LATENCY cycles later, which is
// the cycle at whose end HI/LO get written.
module md_sequencer
   import ctrl_pkg::*;
#(
   parameter int MD_LATENCY = 32,
   parameter int CNTW       = $clog2(MD_LATENCY + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic mdopE,
   output logic mdbusy,
   output logic mddone
);

   md_state_t       state_q, state_d;
   logic [CNTW-1:0] count_q, count_d;

   // State and counter registers; reset abandons any operation in flight,
   // so no late mddone can appear after reset is released.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Next state and outputs. The counter starts at MD_LATENCY-2 because the
   // IDLE->BUSY transition and the DONE cycle account for two of the cycles.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      mdbusy  = 1'b0;
      mddone  = 1'b0;
      case (state_q)
         IDLE: begin
            if (mdopE) begin
               state_d = BUSY;
               count_d = CNTW'(MD_LATENCY - 2);
            end
         end
         BUSY: begin
            mdbusy = 1'b1;
            if (count_q == '0) begin
               state_d = DONE;
            end else begin
               count_d = count_q - CNTW'(1);
            end
         end
         DONE: begin
            mdbusy  = 1'b1;
            mddone  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

endmodule

// File: rtl/pipeline_ctrl_md.sv
// Pipeline controller: decodes the D-stage instruction, carries its controls
// through E, M and W, and interlocks mult/div and mfhi/mflo against the
// multi-cycle multiply/divide unit.
module pipeline_ctrl_md
   import ctrl_pkg::*;
#(
   parameter int ALUCW      = 4,
   parameter int MD_LATENCY = 32,
   parameter int CNTW       = $clog2(MD_LATENCY + 1)
) (
   input logic              clk,
   input logic              reset,
   pipeline_ctrl_md_if.slave ctrl
);

   ctrl_t      ctrlD;
   logic       branchD, bneD, jumpD, jrD, mfhiloD;
   logic [5:0] aluR;

   ctrl_t      ctrlE_d, ctrlE_q;
   logic       regwriteM_q, memwriteM_q;
   logic [1:0] memtoregM_q;
   logic       regwriteW_q;
   logic [1:0] memtoregW_q;

   logic       mdbusy, mddone, stallMD;

   assign aluR = rtypeAlu(ctrl.functD);

   // Main decoder. Anything not recognised leaves every control at zero so a
   // garbage opcode behaves as a harmless bubble.
   always_comb begin
      ctrlD   = '0;
      branchD = 1'b0;
      bneD    = 1'b0;
      jumpD   = 1'b0;
      jrD     = 1'b0;
      mfhiloD = 1'b0;
      case (ctrl.opD)
         OP_RTYPE: begin
            if (aluR[5]) begin
               ctrlD.regWrite = 1'b1;
               ctrlD.regDst   = 2'b01;
               ctrlD.shift    = aluR[4];
               ctrlD.aluCode  = aluR[3:0];
            end else begin
               case (ctrl.functD)
                  FN_JR: jrD = 1'b1;
                  FN_MFHI, FN_MFLO: begin
                     mfhiloD        = 1'b1;
                     ctrlD.regWrite = 1'b1;
                     ctrlD.regDst   = 2'b01;
                  end
                  FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                     ctrlD.mdOp     = 1'b1;
                     ctrlD.mdSigned = ~ctrl.functD[0];
                     ctrlD.mdDiv    = ctrl.functD[1];
                  end
                  default: ;
               endcase
            end
         end
         OP_LW: begin
            ctrlD.regWrite = 1'b1;
            ctrlD.memToReg = 2'b01;
            ctrlD.aluSrc   = 1'b1;
            ctrlD.aluCode  = ALU_ADD;
         end
         OP_SW: begin
            ctrlD.memWrite = 1'b1;
            ctrlD.aluSrc   = 1'b1;
            ctrlD.aluCode  = ALU_ADD;
         end
         OP_BEQ: begin
            branchD       = 1'b1;
            ctrlD.aluCode = ALU_SUB;
         end
         OP_BNE: begin
            bneD          = 1'b1;
            ctrlD.aluCode = ALU_SUB;
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            ctrlD.regWrite = 1'b1;
            ctrlD.aluSrc   = 1'b1;
            case (ctrl.opD)
               OP_SLTI  : ctrlD.aluCode = ALU_SLT;
               OP_SLTIU : ctrlD.aluCode = ALU_SLTU;
               OP_ANDI  : ctrlD.aluCode = ALU_AND;
               OP_ORI   : ctrlD.aluCode = ALU_OR;
               OP_XORI  : ctrlD.aluCode = ALU_XOR;
               OP_LUI   : ctrlD.aluCode = ALU_LUI;
               default  : ctrlD.aluCode = ALU_ADD;
            endcase
         end
         OP_J: jumpD = 1'b1;
         OP_JAL: begin
            jumpD          = 1'b1;
            ctrlD.regWrite = 1'b1;
            ctrlD.regDst   = 2'b10;
            ctrlD.memToReg = 2'b10;
         end
         default: ;
      endcase
   end

   // A mult/div or HI/LO read in D must wait while the unit is (or is about to
   // become) occupied; the held instruction is replaced in E by a bubble.
   always_comb begin
      stallMD = (mdbusy | ctrlE_q.mdOp) & (ctrlD.mdOp | mfhiloD);
      ctrlE_d = (ctrl.flushE | stallMD) ? '0 : ctrlD;
   end

   // D->E control register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrlE_q <= '0;
      end else begin
         ctrlE_q <= ctrlE_d;
      end
   end

   // E->M and M->W registers advance every cycle with no enable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regwriteM_q <= 1'b0;
         memtoregM_q <= 2'b00;
         memwriteM_q <= 1'b0;
         regwriteW_q <= 1'b0;
         memtoregW_q <= 2'b00;
      end else begin
         regwriteM_q <= ctrlE_q.regWrite;
         memtoregM_q <= ctrlE_q.memToReg;
         memwriteM_q <= ctrlE_q.memWrite;
         regwriteW_q <= regwriteM_q;
         memtoregW_q <= memtoregM_q;
      end
   end

   md_sequencer #(
      .MD_LATENCY (MD_LATENCY),
      .CNTW       (CNTW)
   ) u_seq (
      .clk    (clk),
      .reset  (reset),
      .mdopE  (ctrlE_q.mdOp),
      .mdbusy (mdbusy),
      .mddone (mddone)
   );

   assign ctrl.pcsrcD      = (branchD & ctrl.equalD) | (bneD & ~ctrl.equalD);
   assign ctrl.branchD     = branchD;
   assign ctrl.bneD        = bneD;
   assign ctrl.jumpD       = jumpD;
   assign ctrl.jrD         = jrD;

   assign ctrl.regwriteE   = ctrlE_q.regWrite;
   assign ctrl.memtoregE   = ctrlE_q.memToReg;
   assign ctrl.alusrcE     = ctrlE_q.aluSrc;
   assign ctrl.regdstE     = ctrlE_q.regDst;
   assign ctrl.shiftE      = ctrlE_q.shift;
   assign ctrl.alucontrolE = ALUCW'(ctrlE_q.aluCode);
   assign ctrl.mdopE       = ctrlE_q.mdOp;
   assign ctrl.mdsignedE   = ctrlE_q.mdSigned;
   assign ctrl.mddivE      = ctrlE_q.mdDiv;

   assign ctrl.regwriteM   = regwriteM_q;
   assign ctrl.memtoregM   = memtoregM_q;
   assign ctrl.memwriteM   = memwriteM_q;
   assign ctrl.regwriteW   = regwriteW_q;
   assign ctrl.memtoregW   = memtoregW_q;

   assign ctrl.mdbusy      = mdbusy;
   assign ctrl.mddone      = mddone;
   assign ctrl.stallMD     = stallMD;

endmodule

// File: tb/tb_pipeline_ctrl_md.sv
// Scoreboard bench for pipeline_ctrl_md: stimulus pushes hand-computed expected
// output fields tagged with the cycle they must appear in; a negedge monitor
// compares them, and separately matches every mddone pulse against its slot.
module tb_pipeline_ctrl_md;

   typedef struct packed {
      logic       pcsrcD, branchD, bneD, jumpD, jrD;
      logic       regwriteE;
      logic [1:0] memtoregE;
      logic       alusrcE;
      logic [1:0] regdstE;
      logic       shiftE;
      logic [3:0] alucontrolE;
      logic       mdopE, mdsignedE, mddivE;
      logic       regwriteM;
      logic [1:0] memtoregM;
      logic       memwriteM;
      logic       regwriteW;
      logic [1:0] memtoregW;
      logic       mdbusy, mddone, stallMD;
   } obs_t;

   typedef struct {
      int    cyc;
      obs_t  mask;
      obs_t  val;
      string name;
   } exp_t;

   localparam logic [5:0] R    = 6'b000000;
   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] BNE  = 6'b000101;
   localparam logic [5:0] ORI  = 6'b001101;
   localparam logic [5:0] JAL  = 6'b000011;
   localparam logic [5:0] NOPC = 6'b111111;

   logic clk = 1'b0;
   logic reset;
   int   cycNow = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t expQ[$];
   int   doneQ[$];

   pipeline_ctrl_md_if #(.ALUCW(4)) bus ();

   pipeline_ctrl_md #(.ALUCW(4), .MD_LATENCY(32)) dut (
      .clk   (clk),
      .reset (reset),
      .ctrl  (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycNow <= cycNow + 1;

   function automatic obs_t dVal(int pc, int br, int bn, int j, int jr);
      obs_t v = '0;
      v.pcsrcD = 1'(pc); v.branchD = 1'(br); v.bneD = 1'(bn); v.jumpD = 1'(j); v.jrD = 1'(jr);
      return v;
   endfunction

   function automatic obs_t eVal(int rw, int mtr, int as, int rd, int sh, int alu, int md, int ms, int mdv);
      obs_t v = '0;
      v.regwriteE = 1'(rw); v.memtoregE = 2'(mtr); v.alusrcE = 1'(as); v.regdstE = 2'(rd);
      v.shiftE = 1'(sh); v.alucontrolE = 4'(alu); v.mdopE = 1'(md); v.mdsignedE = 1'(ms); v.mddivE = 1'(mdv);
      return v;
   endfunction

   function automatic obs_t mVal(int rw, int mtr, int mw);
      obs_t v = '0;
      v.regwriteM = 1'(rw); v.memtoregM = 2'(mtr); v.memwriteM = 1'(mw);
      return v;
   endfunction

   function automatic obs_t wVal(int rw, int mtr);
      obs_t v = '0;
      v.regwriteW = 1'(rw); v.memtoregW = 2'(mtr);
      return v;
   endfunction

   function automatic obs_t sVal(int busy, int done, int stall);
      obs_t v = '0;
      v.mdbusy = 1'(busy); v.mddone = 1'(done); v.stallMD = 1'(stall);
      return v;
   endfunction

   function automatic obs_t maskD();
      return dVal(1, 1, 1, 1, 1);
   endfunction

   function automatic obs_t maskE();
      return eVal(1, 3, 1, 3, 1, 15, 1, 1, 1);
   endfunction

   function automatic obs_t maskM();
      return mVal(1, 3, 1);
   endfunction

   function automatic obs_t maskW();
      return wVal(1, 3);
   endfunction

   function automatic obs_t maskS();
      return sVal(1, 1, 1);
   endfunction

   task automatic pushExp(input int cyc, input string nm, input obs_t m, input obs_t v);
      exp_t e;
      e.cyc = cyc; e.mask = m; e.val = v; e.name = nm;
      expQ.push_back(e);
   endtask

   // Drives one D-stage instruction for one cycle.
   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input int eq, input int fl);
      bus.opD    = op;
      bus.functD = fn;
      bus.equalD = 1'(eq);
      bus.flushE = 1'(fl);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(NOPC, 6'b000000, 0, 0);
   endtask

   // Issues one instruction and records its expected D, E, M and W controls.
   task automatic instr(input string nm, input logic [5:0] op, input logic [5:0] fn, input int eq,
                        input int fl, input obs_t dv, input obs_t ev, input obs_t mv, input obs_t wv);
      int k;
      k = cycNow;
      pushExp(k,     {nm, "_D"}, maskD(), dv);
      pushExp(k + 1, {nm, "_E"}, maskE(), ev);
      pushExp(k + 2, {nm, "_M"}, maskM(), mv);
      pushExp(k + 3, {nm, "_W"}, maskW(), wv);
      applyStimulus(op, fn, eq, fl);
   endtask

   task automatic checkOutput(input exp_t e, input obs_t s);
      obs_t got;
      got = s & e.mask;
      checks++;
      if (got !== e.val) begin
         errors++;
         $display("[TB] FAIL %s cyc %0d got %h expected %h", e.name, e.cyc, got, e.val);
      end
   endtask

   // Monitor: samples on the falling edge, retires every expectation due now,
   // and checks that mddone pulses exactly and only where one was scheduled.
   always @(negedge clk) begin
      obs_t s;
      logic wantDone;
      s.pcsrcD = bus.pcsrcD; s.branchD = bus.branchD; s.bneD = bus.bneD;
      s.jumpD = bus.jumpD; s.jrD = bus.jrD;
      s.regwriteE = bus.regwriteE; s.memtoregE = bus.memtoregE; s.alusrcE = bus.alusrcE;
      s.regdstE = bus.regdstE; s.shiftE = bus.shiftE; s.alucontrolE = bus.alucontrolE;
      s.mdopE = bus.mdopE; s.mdsignedE = bus.mdsignedE; s.mddivE = bus.mddivE;
      s.regwriteM = bus.regwriteM; s.memtoregM = bus.memtoregM; s.memwriteM = bus.memwriteM;
      s.regwriteW = bus.regwriteW; s.memtoregW = bus.memtoregW;
      s.mdbusy = bus.mdbusy; s.mddone = bus.mddone; s.stallMD = bus.stallMD;
      for (int i = expQ.size() - 1; i >= 0; i--) begin
         if (expQ[i].cyc == cycNow) begin
            checkOutput(expQ[i], s);
            expQ.delete(i);
         end
      end
      wantDone = (doneQ.size() > 0) && (doneQ[0] == cycNow);
      if (wantDone || bus.mddone !== 1'b0) begin
         checks++;
         if (bus.mddone !== wantDone) begin
            errors++;
            $display("[TB] FAIL mddone_pulse cyc %0d got %b expected %b", cycNow, bus.mddone, wantDone);
         end
         if (wantDone) void'(doneQ.pop_front());
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at cyc %0d", cycNow);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int k, t;
      reset = 1'b0;
      idle(1);
      pushExp(cycNow, "reset_hold", '1, '0);
      idle(1);
      reset = 1'b1;
      pushExp(cycNow, "post_reset", '1, '0);
      idle(2);

      instr("lw",     LW,  6'b000000, 0, 0, '0, eVal(1, 1, 1, 0, 0, 2, 0, 0, 0), mVal(1, 1, 0), wVal(1, 1));
      instr("sw",     SW,  6'b000000, 0, 0, '0, eVal(0, 0, 1, 0, 0, 2, 0, 0, 0), mVal(0, 0, 1), '0);
      instr("beq_eq", BEQ, 6'b000000, 1, 0, dVal(1, 1, 0, 0, 0), eVal(0, 0, 0, 0, 0, 6, 0, 0, 0), '0, '0);
      instr("beq_ne", BEQ, 6'b000000, 0, 0, dVal(0, 1, 0, 0, 0), eVal(0, 0, 0, 0, 0, 6, 0, 0, 0), '0, '0);
      instr("bne_eq", BNE, 6'b000000, 1, 0, dVal(0, 0, 1, 0, 0), eVal(0, 0, 0, 0, 0, 6, 0, 0, 0), '0, '0);
      instr("bne_ne", BNE, 6'b000000, 0, 0, dVal(1, 0, 1, 0, 0), eVal(0, 0, 0, 0, 0, 6, 0, 0, 0), '0, '0);
      instr("add",    R,   6'b100000, 0, 0, '0, eVal(1, 0, 0, 1, 0, 2, 0, 0, 0), mVal(1, 0, 0), wVal(1, 0));
      instr("sll",    R,   6'b000000, 0, 0, '0, eVal(1, 0, 0, 1, 1, 5, 0, 0, 0), mVal(1, 0, 0), wVal(1, 0));
      instr("ori",    ORI, 6'b000000, 0, 0, '0, eVal(1, 0, 1, 0, 0, 1, 0, 0, 0), mVal(1, 0, 0), wVal(1, 0));
      instr("jal",    JAL, 6'b000000, 0, 0, dVal(0, 0, 0, 1, 0), eVal(1, 2, 0, 2, 0, 0, 0, 0, 0), mVal(1, 2, 0), wVal(1, 2));
      instr("jr",     R,   6'b001000, 0, 0, dVal(0, 0, 0, 0, 1), '0, '0, '0);
      instr("badop",  6'b111110, 6'b000000, 1, 0, '0, '0, '0, '0);
      instr("badfn",  R,   6'b111111, 0, 0, '0, '0, '0, '0);
      instr("lw_fl",  LW,  6'b000000, 0, 1, '0, '0, '0, '0);
      idle(4);

      k = cycNow;
      pushExp(k + 1, "mult_E", maskE(), eVal(0, 0, 0, 0, 0, 0, 1, 1, 0));
      applyStimulus(R, 6'b011000, 0, 0);
      t = cycNow;
      doneQ.push_back(t + 32);
      pushExp(t,      "mult_seq_t",    maskS(), sVal(0, 0, 1));
      pushExp(t + 1,  "mult_seq_t1",   maskS(), sVal(1, 0, 1));
      pushExp(t + 16, "mult_seq_t16",  maskS(), sVal(1, 0, 1));
      pushExp(t + 31, "mult_seq_t31",  maskS(), sVal(1, 0, 1));
      pushExp(t + 32, "mult_seq_t32",  maskS(), sVal(1, 1, 1));
      pushExp(t + 33, "mult_seq_t33",  maskS(), sVal(0, 0, 0));
      pushExp(t + 1,  "bubble_t1",     maskE(), '0);
      pushExp(t + 16, "bubble_t16",    maskE(), '0);
      pushExp(t + 33, "bubble_t33",    maskE(), '0);
      pushExp(t + 34, "mflo_E",        maskE(), eVal(1, 0, 0, 1, 0, 0, 0, 0, 0));
      repeat (34) applyStimulus(R, 6'b010010, 0, 0);
      idle(3);

      k = cycNow;
      pushExp(k + 1, "divu_E", maskE(), eVal(0, 0, 0, 0, 0, 0, 1, 0, 1));
      applyStimulus(R, 6'b011011, 0, 0);
      t = cycNow;
      doneQ.push_back(t + 32);
      pushExp(t + 32, "divu_seq_t32", maskS(), sVal(1, 1, 0));
      pushExp(t + 33, "divu_seq_t33", maskS(), sVal(0, 0, 0));
      idle(36);

      k = cycNow;
      pushExp(k + 1, "divu_fl_E",   maskE(), '0);
      pushExp(k + 1, "divu_fl_s1",  maskS(), '0);
      pushExp(k + 2, "divu_fl_s2",  maskS(), '0);
      pushExp(k + 6, "divu_fl_s6",  maskS(), '0);
      applyStimulus(R, 6'b011011, 0, 1);
      idle(8);

      k = cycNow;
      pushExp(k + 1, "div_E", maskE(), eVal(0, 0, 0, 0, 0, 0, 1, 1, 1));
      applyStimulus(R, 6'b011010, 0, 0);
      t = cycNow;
      pushExp(t + 1,  "div_seq_t1",  maskS(), sVal(1, 0, 0));
      pushExp(t + 3,  "div_noabort", maskS(), sVal(1, 0, 0));
      pushExp(t + 3,  "add_nostall", maskS(), sVal(1, 0, 0));
      pushExp(t + 4,  "add_busy_E",  maskE(), eVal(1, 0, 0, 1, 0, 2, 0, 0, 0));
      pushExp(t + 9,  "div_seq_t9",  maskS(), sVal(1, 0, 0));
      idle(2);
      applyStimulus(NOPC, 6'b000000, 0, 1);
      applyStimulus(R, 6'b100000, 0, 0);
      idle(6);
      reset = 1'b0;
      pushExp(cycNow,     "rst_mid",   '1, '0);
      pushExp(cycNow + 1, "rst_mid2",  '1, '0);
      idle(2);
      reset = 1'b1;
      pushExp(cycNow + 1,  "rst_after1",  maskS(), '0);
      pushExp(cycNow + 28, "rst_after28", maskS(), '0);
      idle(40);

      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL pending_expectations got %0d expected 0", expQ.size());
      end
      checks++;
      if (doneQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL missing_mddone got %0d outstanding expected 0", doneQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
